// File: rtl/led_pkg.sv
// Mode encodings shared by the LED controller and its register front end.
// A channel mode occupies MODE_W bits of the packed mode word.
package led_pkg;

    localparam int unsigned MODE_W = 4;

    localparam logic [MODE_W-1:0] LED_OFF   = 4'd0;
    localparam logic [MODE_W-1:0] LED_ON    = 4'd1;
    localparam logic [MODE_W-1:0] LED_SPARK = 4'd2;
    localparam logic [MODE_W-1:0] LED_BLINK = 4'd3;
    localparam logic [MODE_W-1:0] LED_PWM   = 4'd4;

endpackage

// File: rtl/led_shift_n.sv
// Frame serializer for a 74HC595-style chain: snapshots din when it differs from the
// last frame sent, shifts it out MSB first, then pulses the storage clock.
module led_shift_n #(
    parameter int unsigned NUM_LED   = 8,
    parameter int unsigned SHIFT_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               vld,
    input  logic [NUM_LED-1:0] din,
    output logic               busy,
    output logic               done,
    output logic               sft_shcp,
    output logic               sft_stcp,
    output logic               sft_ds
);

    localparam int unsigned DIV_W = $clog2(2 * SHIFT_DIV);
    localparam int unsigned BIT_W = (NUM_LED > 1) ? $clog2(NUM_LED) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_LATCH = 2'd2;

    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(SHIFT_DIV);
    localparam logic [DIV_W-1:0] DIV_BIT   = DIV_W'(2 * SHIFT_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LATCH = DIV_W'(SHIFT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(NUM_LED - 1);

    logic [1:0]         state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [NUM_LED-1:0] sreg_q, sreg_d;
    logic [NUM_LED-1:0] sent_q, sent_d;
    logic               dirty_q, dirty_d;
    logic               done_q, done_d;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sreg_d  = sreg_q;
        sent_d  = sent_q;
        dirty_d = dirty_q;
        done_d  = 1'b0;

        // Sticky: a change seen mid-frame forces one more frame afterwards.
        if (vld && (din != sent_q)) begin
            dirty_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (dirty_q) begin
                    sreg_d  = din;
                    sent_d  = din;
                    dirty_d = 1'b0;
                    div_d   = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_q == DIV_BIT) begin
                    div_d  = '0;
                    sreg_d = sreg_q << 1;
                    if (bit_q == BIT_LAST) begin
                        state_d = ST_LATCH;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (div_q == DIV_LATCH) begin
                    div_d   = '0;
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sreg_q  <= '0;
            sent_q  <= '0;
            dirty_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sreg_q  <= sreg_d;
            sent_q  <= sent_d;
            dirty_q <= dirty_d;
            done_q  <= done_d;
        end
    end

    // Pin outputs decode straight from state so a reset drops them on the next cycle.
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;
    assign sft_shcp = (state_q == ST_SHIFT) && (div_q >= DIV_HALF);
    assign sft_stcp = (state_q == ST_LATCH);
    assign sft_ds   = (state_q == ST_SHIFT) && sreg_q[NUM_LED-1];

endmodule

// File: rtl/led_ctrl_n.sv
// N-channel LED controller: per-channel off/on/spark/blink/PWM/hold state driven by a
// packed mode word, serialized to an external shift-register chain on every change.
module led_ctrl_n
    import led_pkg::*;
#(
    parameter int unsigned NUM_LED   = 8,
    parameter int unsigned CNT_W     = 25,
    parameter int unsigned SPARK_MAX = 15000000,
    parameter int unsigned PWM_W     = 8,
    parameter int unsigned SHIFT_DIV = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      vld,
    input  logic [MODE_W*NUM_LED-1:0] reg_din,
    input  logic [PWM_W-1:0]          reg_duty,
    output logic                      sft_shcp,
    output logic                      sft_stcp,
    output logic                      sft_ds,
    output logic                      busy,
    output logic                      frame_done
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SPARK_MAX);

    logic [PWM_W-1:0]   pwm_ph_q;
    logic               pwm_on;
    logic [NUM_LED-1:0] led_vec;

    assign pwm_on = (pwm_ph_q < reg_duty);

    // PWM phase advances once per frame, so the dim rate tracks the chain refresh rate.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_ph_q <= '0;
        end else if (frame_done) begin
            pwm_ph_q <= pwm_ph_q + PWM_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
        logic [MODE_W-1:0] mode;
        logic [MODE_W-1:0] mode_q;
        logic              led_q;
        logic [CNT_W-1:0]  cnt_q;
        logic              blink_keep;

        assign mode = reg_din[MODE_W*i +: MODE_W];
        // Rewriting BLINK while already blinking keeps counting, so the phase is undisturbed.
        assign blink_keep = (mode == LED_BLINK) && (mode_q == LED_BLINK) && (cnt_q != '0);

        always_ff @(posedge clk) begin
            if (rst) begin
                mode_q <= LED_OFF;
                led_q  <= 1'b0;
                cnt_q  <= '0;
            end else if (vld && !blink_keep) begin
                mode_q <= mode;
                case (mode)
                    LED_OFF: begin
                        led_q <= 1'b0;
                        cnt_q <= '0;
                    end
                    LED_ON: begin
                        led_q <= 1'b1;
                        cnt_q <= '0;
                    end
                    LED_SPARK, LED_BLINK: begin
                        led_q <= 1'b1;
                        cnt_q <= CNT_W'(1);
                    end
                    LED_PWM: begin
                        led_q <= pwm_on;
                        cnt_q <= '0;
                    end
                    default: ;
                endcase
            end else begin
                case (mode_q)
                    LED_SPARK, LED_BLINK: begin
                        if (cnt_q == CNT_MAX) begin
                            led_q <= (mode_q == LED_BLINK) ? !led_q : 1'b0;
                            cnt_q <= (mode_q == LED_BLINK) ? CNT_W'(1) : '0;
                        end else if (cnt_q != '0) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    LED_PWM: led_q <= pwm_on;
                    default: ;
                endcase
            end
        end

        assign led_vec[i] = led_q;
    end

    led_shift_n #(
        .NUM_LED  (NUM_LED),
        .SHIFT_DIV(SHIFT_DIV)
    ) u_shift (
        .clk     (clk),
        .rst     (rst),
        .vld     (1'b1),
        .din     (led_vec),
        .busy    (busy),
        .done    (frame_done),
        .sft_shcp(sft_shcp),
        .sft_stcp(sft_stcp),
        .sft_ds  (sft_ds)
    );

endmodule
